// File: rtl/sram_timer64.sv
// rtl/sram_timer64.sv - memory-mapped 64-bit timer with compare interrupt
// Four 64-bit words selected by addra[4:3]: MTIME, MTIMECMP, CTRL, STATUS.
module sram_timer64 #(
  parameter int LEN_ADDR = 64,
  parameter int PRESC_W  = 8
) (
  input  logic                clka,
  input  logic                rst,
  input  logic [LEN_ADDR-1:0] addra,
  input  logic [63:0]         dina,
  output logic [63:0]         douta,
  input  logic                ena,
  input  logic [7:0]          wea,
  output logic                timer_irq
);

  localparam logic [1:0] SEL_MTIME  = 2'd0;
  localparam logic [1:0] SEL_CMP    = 2'd1;
  localparam logic [1:0] SEL_CTRL   = 2'd2;
  localparam logic [1:0] SEL_STATUS = 2'd3;

  logic [63:0]        mtime_q, mtime_d;
  logic [63:0]        mtimecmp_q, mtimecmp_d;
  logic               en_q, en_d;
  logic               irq_en_q, irq_en_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] pcnt_q, pcnt_d;
  logic               ovf_q, ovf_d;
  logic [63:0]        douta_q, douta_d;
  logic               irq_q, irq_d;

  logic [1:0]  sel;
  logic        wr;
  logic        tick;
  logic        pend;
  logic        wrap;
  logic [63:0] ctrl_rd;
  logic [63:0] status_rd;
  logic [63:0] rdata;

  // Only the word-select bits matter; the rest of the address is don't-care.
  logic unused_addr;
  assign unused_addr = ^{addra[LEN_ADDR-1:5], addra[2:0]};

  function automatic logic [63:0] byte_merge(input logic [63:0] old_v,
                                             input logic [63:0] new_v,
                                             input logic [7:0]  be);
    logic [63:0] r;
    for (int b = 0; b < 8; b++) begin
      r[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return r;
  endfunction

  always_comb begin
    sel  = addra[4:3];
    wr   = ena && (wea != 8'h00);
    pend = (mtime_q >= mtimecmp_q);
    tick = en_q && (pcnt_q == presc_q);
    // An MTIME write swallows the tick, so it can neither increment nor wrap.
    wrap = tick && (&mtime_q) && !(wr && sel == SEL_MTIME);

    ctrl_rd                  = 64'h0;
    ctrl_rd[0]               = en_q;
    ctrl_rd[1]               = irq_en_q;
    ctrl_rd[8 +: PRESC_W]    = presc_q;
    status_rd                = {62'h0, ovf_q, pend};

    case (sel)
      SEL_MTIME: rdata = mtime_q;
      SEL_CMP:   rdata = mtimecmp_q;
      SEL_CTRL:  rdata = ctrl_rd;
      default:   rdata = status_rd;
    endcase

    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    en_d       = en_q;
    irq_en_d   = irq_en_q;
    presc_d    = presc_q;
    ovf_d      = ovf_q;
    douta_d    = ena ? rdata : douta_q;
    irq_d      = pend && irq_en_q;

    if (wr && sel == SEL_MTIME) begin
      mtime_d = byte_merge(mtime_q, dina, wea);
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end

    if (wr && sel == SEL_CMP) begin
      mtimecmp_d = byte_merge(mtimecmp_q, dina, wea);
    end

    if (wr && sel == SEL_CTRL) begin
      if (wea[0]) begin
        en_d     = dina[0];
        irq_en_d = dina[1];
      end
      for (int i = 0; i < PRESC_W; i++) begin
        if (wea[(8 + i) / 8]) presc_d[i] = dina[8 + i];
      end
    end

    if (wr && sel == SEL_STATUS && wea[0] && dina[1]) ovf_d = 1'b0;
    if (wrap) ovf_d = 1'b1;

    // Restarting the prescaler on any CTRL write gives a full period to the first tick.
    if ((wr && sel == SEL_CTRL) || !en_q || tick) begin
      pcnt_d = '0;
    end else begin
      pcnt_d = pcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clka) begin
    if (rst) begin
      mtime_q    <= 64'h0;
      mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      en_q       <= 1'b0;
      irq_en_q   <= 1'b0;
      presc_q    <= '0;
      pcnt_q     <= '0;
      ovf_q      <= 1'b0;
      douta_q    <= 64'h0;
      irq_q      <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      en_q       <= en_d;
      irq_en_q   <= irq_en_d;
      presc_q    <= presc_d;
      pcnt_q     <= pcnt_d;
      ovf_q      <= ovf_d;
      douta_q    <= douta_d;
      irq_q      <= irq_d;
    end
  end

  assign douta     = douta_q;
  assign timer_irq = irq_q;

endmodule

// File: tb/tb_sram_timer64.sv
// tb/tb_sram_timer64.sv - directed self-checking bench for sram_timer64
module tb_sram_timer64;

  logic        clka;
  logic        rst;
  logic [63:0] addra;
  logic [63:0] dina;
  logic [63:0] douta;
  logic        ena;
  logic [7:0]  wea;
  logic        timer_irq;

  int nvec = 0;
  int nerr = 0;

  sram_timer64 #(.LEN_ADDR(64), .PRESC_W(8)) dut (
    .clka      (clka),
    .rst       (rst),
    .addra     (addra),
    .dina      (dina),
    .douta     (douta),
    .ena       (ena),
    .wea       (wea),
    .timer_irq (timer_irq)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  task automatic cyc();
    @(posedge clka);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] sel, input logic [63:0] data, input logic [7:0] be);
    ena   = 1'b1;
    addra = {59'h0, sel, 3'b000};
    dina  = data;
    wea   = be;
    cyc();
    ena = 1'b0;
    wea = 8'h00;
  endtask

  task automatic rd(input logic [1:0] sel, output logic [63:0] data);
    ena   = 1'b1;
    addra = {59'h0, sel, 3'b000};
    wea   = 8'h00;
    cyc();
    ena  = 1'b0;
    data = douta;
  endtask

  logic [63:0] v;

  initial begin
    rst = 1'b1; ena = 1'b1; wea = 8'hFF; dina = '1; addra = 64'h0;
    cyc(); cyc();
    rst = 1'b0; ena = 1'b0; wea = 8'h00;

    // Reset values; accesses during reset must have been ignored
    check("rst_douta", douta, 64'h0);
    check("rst_irq", {63'h0, timer_irq}, 64'h0);
    rd(2'd0, v); check("rst_mtime", v, 64'h0);
    rd(2'd1, v); check("rst_mtimecmp", v, 64'hFFFF_FFFF_FFFF_FFFF);
    rd(2'd2, v); check("rst_ctrl", v, 64'h0);
    rd(2'd3, v); check("rst_status", v, 64'h0);

    // CTRL keeps only EN, IRQ_EN and PRESC
    wr(2'd2, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF);
    rd(2'd2, v); check("ctrl_mask", v, 64'h0000_0000_0000_FF02);
    wr(2'd2, 64'h0, 8'hFF);

    // PRESC=3: MTIME steps at the 4th, 8th, 12th edge after the CTRL write
    wr(2'd0, 64'h0, 8'hFF);
    wr(2'd2, 64'h0301, 8'hFF);
    ena = 1'b1; addra = 64'h0;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      check($sformatf("presc3_k%0d", k), douta, 64'((k - 1) / 4));
    end
    ena = 1'b0;
    rd(2'd0, v); check("presc3_mtime3", v, 64'd3);

    // Compare interrupt rises one cycle after MTIME reaches 5
    wr(2'd2, 64'h0, 8'hFF);
    wr(2'd0, 64'h0, 8'hFF);
    wr(2'd1, 64'd5, 8'hFF);
    wr(2'd2, 64'h0003, 8'hFF);
    for (int k = 1; k <= 6; k++) begin
      cyc();
      check($sformatf("irq_rise_k%0d", k), {63'h0, timer_irq}, (k >= 6) ? 64'd1 : 64'd0);
    end
    wr(2'd1, 64'd100, 8'hFF);
    check("irq_hold", {63'h0, timer_irq}, 64'd1);
    cyc();
    check("irq_fall", {63'h0, timer_irq}, 64'd0);

    // Wrap sets OVF; W1C clears it
    wr(2'd2, 64'h0, 8'hFF);
    wr(2'd1, 64'h0, 8'hFF);
    wr(2'd0, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF);
    wr(2'd2, 64'h0001, 8'hFF);
    rd(2'd0, v); check("wrap_fe", v, 64'hFFFF_FFFF_FFFF_FFFE);
    rd(2'd0, v); check("wrap_ff", v, 64'hFFFF_FFFF_FFFF_FFFF);
    rd(2'd0, v); check("wrap_00", v, 64'h0);
    rd(2'd3, v); check("wrap_status", v, 64'h3);
    wr(2'd2, 64'h0, 8'hFF);
    wr(2'd3, 64'h2, 8'h01);
    rd(2'd3, v); check("ovf_cleared", v, 64'h1);

    // MTIME byte write on a tick cycle: no increment, read-before-write
    wr(2'd0, 64'h10, 8'hFF);
    wr(2'd2, 64'h0001, 8'hFF);
    wr(2'd0, 64'hFFFF_FFFF_FFFF_FFAA, 8'h01);
    check("rbw_old", douta, 64'h10);
    rd(2'd0, v); check("wr_beats_tick", v, 64'hAA);

    // Reset mid-count with irq asserted
    wr(2'd1, 64'h0, 8'hFF);
    wr(2'd2, 64'h0003, 8'hFF);
    cyc(); cyc();
    check("pre_rst_irq", {63'h0, timer_irq}, 64'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("post_rst_irq", {63'h0, timer_irq}, 64'd0);
    rd(2'd0, v); check("post_rst_mtime", v, 64'h0);
    for (int k = 0; k < 5; k++) cyc();
    rd(2'd0, v); check("post_rst_held", v, 64'h0);
    rd(2'd3, v); check("post_rst_status", v, 64'h0);
    wr(2'd2, 64'h0001, 8'hFF);
    cyc(); cyc();
    rd(2'd0, v); check("restart_mtime", v, 64'd2);
    check("restart_irq", {63'h0, timer_irq}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/sram_timer64.md
SRAM_TIMER64 -- requirements
Module: sram_timer64

Interface
REQ-001 SHALL have parameter LEN_ADDR, default 64: width of addra.
REQ-002 SHALL have parameter PRESC_W, default 8: width of the prescaler field and prescaler counter.
REQ-003 SHALL have port clka, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port addra, input, LEN_ADDR: byte address; only addra[4:3] decoded (word select), other bits ignored.
REQ-006 SHALL have port dina, input, 64: write data.
REQ-007 SHALL have port douta, output, 64: read data, registered.
REQ-008 SHALL have port ena, input, 1: access strobe.
REQ-009 SHALL have port wea, input, 8: per-byte write enables; wea[i] qualifies dina[8i+7:8i].
REQ-010 SHALL have port timer_irq, output, 1: registered timer interrupt, level.

Function
REQ-011 SHALL map registers by addra[4:3]: 0 MTIME (RW), 1 MTIMECMP (RW), 2 CTRL (RW), 3 STATUS (read / W1C).
REQ-012 SHALL define CTRL as: bit0 EN; bit1 IRQ_EN; bits[8+PRESC_W-1:8] PRESC; all other bits read 0, writes ignored.
REQ-013 SHALL define STATUS as: bit0 PEND (read-only, = MTIME >= MTIMECMP, unsigned 64-bit); bit1 OVF (sticky); other bits read 0.
REQ-014 SHALL perform a write when ena=1 and wea!=0, updating only the bytes with wea[i]=1.
REQ-015 SHALL load douta, when ena=1, with the addressed register value before any same-cycle write (read-before-write); data visible the cycle after ena (1-cycle latency).
REQ-016 SHALL hold douta unchanged when ena=0.
REQ-017 SHALL, with EN=1, increment the prescaler counter each cycle; when the counter equals PRESC it SHALL clear to 0 and issue a one-cycle tick. PRESC=0 gives a tick every cycle; PRESC=N gives a tick every N+1 cycles.
REQ-018 SHALL, with EN=0, hold MTIME and hold the prescaler counter at 0.
REQ-019 SHALL clear the prescaler counter on any CTRL write, so that the first tick after the write falls PRESC+1 cycles later.
REQ-020 SHALL increment MTIME by 1, modulo 2^64, on each tick.
REQ-021 SHALL set OVF in the cycle MTIME wraps from 0xFFFF_FFFF_FFFF_FFFF to 0.
REQ-022 SHALL give a write to MTIME priority over a same-cycle tick: the unwritten bytes keep their pre-write value, the increment is dropped, and no OVF is set.
REQ-023 SHALL clear OVF on a STATUS write with wea[0]=1 and dina[1]=1; a same-cycle wrap SHALL win, leaving OVF=1.
REQ-024 SHALL register timer_irq each cycle as PEND AND IRQ_EN, with PEND evaluated on the current register values, so the irq lags the register change by 1 cycle.
REQ-025 SHALL recompute PEND on MTIMECMP writes, including partial-byte writes; writing MTIMECMP above MTIME deasserts timer_irq on the cycle after the next edge.

Reset
REQ-026 SHALL, on rst=1 at a clka edge, set: MTIME=0; MTIMECMP=0xFFFF_FFFF_FFFF_FFFF; CTRL=0; OVF=0; prescaler counter=0; douta=0; timer_irq=0.
REQ-027 SHALL ignore ena/wea while rst=1.
REQ-028 SHALL, when rst asserts mid-count, return every register to its reset value at that edge; the first tick after rst deasserts requires EN to be rewritten.

Verification
REQ-029 SHALL verify: reset, then read all four words -> douta = 0, all-ones, 0, 0 on the respective cycles after ena; timer_irq=0.
REQ-030 SHALL verify: CTRL=0x0301 (EN=1, PRESC=3), MTIME=0, wait 12 cycles -> MTIME=3; ticks occur exactly every 4 cycles after the CTRL write.
REQ-031 SHALL verify: MTIMECMP=5, CTRL=0x0003 -> timer_irq rises 1 cycle after MTIME reaches 5; then write MTIMECMP=100 -> timer_irq falls 1 cycle after the write.
REQ-032 SHALL verify: MTIME=0xFFFF_FFFF_FFFF_FFFE, EN=1, PRESC=0 -> wraps to 0 after 2 ticks and STATUS reads 0x3 (PEND=1 since MTIMECMP was set to 0); then write STATUS dina=0x2, wea=0x01 -> OVF reads 0.
REQ-033 SHALL verify: with EN=1, PRESC=0 and MTIME=0x10, write wea=0x01, dina=0xAA on a tick cycle -> MTIME=0xAA exactly (no increment), with upper bytes preserved; a same-cycle read returns the old value.
REQ-034 SHALL verify: assert rst for 1 cycle while counting with irq asserted -> the next cycle shows timer_irq=0 and MTIME=0, and MTIME stays 0 until CTRL is rewritten.
